// File: rtl/sseg_pkg.sv
// Glyph constants and index sizing helper for the seven-segment scan driver.
package sseg_pkg;

  // Cathode patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // A single-digit display still needs a one-bit index register.
  function automatic int unsigned idx_width(input int unsigned num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/sseg_glyph_enc.sv
// Nibble to seven-segment glyph; nibbles 10-15 blank unless hex mode is on.
module sseg_glyph_enc
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = hex_mode_i ? SEG_A : SEG_BLANK;
      4'hB: seg_o = hex_mode_i ? SEG_B : SEG_BLANK;
      4'hC: seg_o = hex_mode_i ? SEG_C : SEG_BLANK;
      4'hD: seg_o = hex_mode_i ? SEG_D : SEG_BLANK;
      4'hE: seg_o = hex_mode_i ? SEG_E : SEG_BLANK;
      4'hF: seg_o = hex_mode_i ? SEG_F : SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered display word.
// Define SSEG_DIM_EN to add a 4-bit brightness input that PWM-gates the active anode.
module sseg_mux_driver
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    hex_mode,
`ifdef SSEG_DIM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned     IdxW   = idx_width(NUM_DIGITS);
  localparam int unsigned     PreW   = $clog2(REFRESH_DIV);
  localparam logic [PreW-1:0] PreMax = PreW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  logic [PreW-1:0]         presc_q, presc_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] stg_data_q, stg_data_d, shd_data_q, shd_data_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
  logic                    pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q;
  logic                    tick, wrap, digit_on, an_on;
  logic [3:0]              nibble;
  logic [6:0]              glyph;
`ifdef SSEG_DIM_EN
  logic [3:0]              pwm_q, pwm_d;
`endif

  sseg_glyph_enc u_glyph (
    .nibble_i  (nibble),
    .hex_mode_i(hex_mode),
    .seg_o     (glyph)
  );

  always_comb begin
    tick    = (presc_q == PreMax);
    wrap    = tick && (idx_q == IdxMax);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) begin
      idx_d = '0;
    end else if (tick) begin
      idx_d = idx_q + 1'b1;
    end

    stg_data_d = stg_data_q;
    stg_dp_d   = stg_dp_q;
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    pend_d     = pend_q;
    if (load) begin
      stg_data_d = data_in;
      stg_dp_d   = dp_in;
      pend_d     = 1'b1;
    end
    // The shadow word only moves at the frame boundary; a same-cycle load bypasses staging.
    if (wrap) begin
      pend_d = 1'b0;
      if (load) begin
        shd_data_d = data_in;
        shd_dp_d   = dp_in;
      end else if (pend_q) begin
        shd_data_d = stg_data_q;
        shd_dp_d   = stg_dp_q;
      end
    end

    nibble   = shd_data_q[{idx_q, 2'b00} +: 4];
    digit_on = digit_en[idx_q];
`ifdef SSEG_DIM_EN
    pwm_d = pwm_q + 1'b1;
    an_on = digit_on && (pwm_q < brightness);
`else
    an_on = digit_on;
`endif
    // Anodes stay dark on the slot-change cycle to avoid ghosting.
    an_d = '1;
    if (!tick && an_on) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = digit_on ? glyph : SEG_BLANK;
    dp_d  = digit_on ? ~shd_dp_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      stg_data_q   <= '0;
      stg_dp_q     <= '0;
      shd_data_q   <= '0;
      shd_dp_q     <= '0;
      pend_q       <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
`ifdef SSEG_DIM_EN
      pwm_q        <= '0;
`endif
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      stg_data_q   <= stg_data_d;
      stg_dp_q     <= stg_dp_d;
      shd_data_q   <= shd_data_d;
      shd_dp_q     <= shd_dp_d;
      pend_q       <= pend_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= wrap;
`ifdef SSEG_DIM_EN
      pwm_q        <= pwm_d;
`endif
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Self-checking bench for sseg_mux_driver with 4 digits and a 4-cycle slot.
module tb_sseg_mux_driver;

  localparam int unsigned N     = 4;
  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = N * DIV;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [15:0] data_in  = '0;
  logic [3:0]  dp_in    = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        load     = 1'b0;
  logic        hex_mode = 1'b1;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
`ifdef SSEG_DIM_EN
  logic [3:0]  brightness = 4'hF;
`endif

  always #5 clk = ~clk;

  sseg_mux_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .load      (load),
    .hex_mode  (hex_mode),
`ifdef SSEG_DIM_EN
    .brightness(brightness),
`endif
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       chk;
  } exp_t;

  // sg holds the expected glyphs {digit3, digit2, digit1, digit0}.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dpi;
    logic        hex;
    logic [3:0]  en;
    logic [27:0] sg;
  } rec_t;

  exp_t       sb_q[$];
  rec_t       recs[5];
  int         passed = 0;
  int         total  = 0;
  int         k      = 0;
  logic [6:0] cur_seg[4];
  logic [6:0] stg_seg[4];
  logic [6:0] ld_seg[4];
  logic [3:0] cur_dp, stg_dp, ld_dp;
  logic       pend, cur_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at k=%0d: got %0h, want %0h", name, k, act, exp);
  endtask

  // Push the expectation for the coming edge, advance the model, then compare.
  task automatic step();
    exp_t e;
    int   kn, d;
    logic bnd, on;
    kn  = k + 1;
    d   = (kn / DIV) % N;
    bnd = (kn % FRAME) == 0;
    on  = digit_en[d] && (kn % DIV != 0);
`ifdef SSEG_DIM_EN
    on  = on && (((kn - 1) % 16) < int'(brightness));
`endif
    e.an  = on ? ~(4'b0001 << d) : 4'hF;
    e.seg = digit_en[d] ? cur_seg[d] : 7'h7F;
    e.dp  = digit_en[d] ? ~cur_dp[d] : 1'b1;
    e.fd  = bnd;
    e.chk = (kn % DIV != 0) && (cur_valid || !digit_en[d]);
    sb_q.push_back(e);
    if (load) begin
      stg_seg = ld_seg;
      stg_dp  = ld_dp;
      pend    = 1'b1;
    end
    if (bnd) begin
      if (load) begin
        cur_seg = ld_seg;
        cur_dp  = ld_dp;
      end else if (pend) begin
        cur_seg = stg_seg;
        cur_dp  = stg_dp;
      end
      if (load || pend) cur_valid = 1'b1;
      pend = 1'b0;
    end
    @(posedge clk);
    #1;
    k = kn;
    e = sb_q.pop_front();
    check("an", 32'(an), 32'(e.an));
    check("frame_done", 32'(frame_done), 32'(e.fd));
    if (e.chk) begin
      check("seg", 32'(seg), 32'(e.seg));
      check("dp", 32'(dp), 32'(e.dp));
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_frame_done", 32'(frame_done), 32'h0);
    end
    rst       = 1'b0;
    k         = 0;
    pend      = 1'b0;
    cur_valid = 1'b1;
    cur_dp    = '0;
    for (int i = 0; i < 4; i++) cur_seg[i] = 7'h40;
  endtask

  task automatic set_word(input logic [15:0] w, input logic [3:0] p, input logic [27:0] sg);
    data_in = w;
    dp_in   = p;
    ld_dp   = p;
    for (int i = 0; i < 4; i++) ld_seg[i] = sg[7*i +: 7];
  endtask

  task automatic apply_rec(input rec_t r);
    hex_mode  = r.hex;
    digit_en  = r.en;
    cur_valid = 1'b0;
    set_word(r.data, r.dpi, r.sg);
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (k % FRAME == 0) break;
    end
    repeat (FRAME) step();
  endtask

  initial begin
    recs[0] = '{data: 16'hF905, dpi: 4'b0010, hex: 1'b1, en: 4'hF,
                sg: {7'h0E, 7'h10, 7'h40, 7'h12}};
    recs[1] = '{data: 16'hF905, dpi: 4'b0010, hex: 1'b0, en: 4'hF,
                sg: {7'h7F, 7'h10, 7'h40, 7'h12}};
    recs[2] = '{data: 16'h6D21, dpi: 4'b0000, hex: 1'b0, en: 4'hF,
                sg: {7'h02, 7'h7F, 7'h24, 7'h79}};
    recs[3] = '{data: 16'h3CA7, dpi: 4'b1000, hex: 1'b1, en: 4'b1011,
                sg: {7'h30, 7'h46, 7'h08, 7'h78}};
    recs[4] = '{data: 16'h8BE4, dpi: 4'b0101, hex: 1'b1, en: 4'hF,
                sg: {7'h00, 7'h03, 7'h06, 7'h19}};

    do_reset();
    repeat (2 * FRAME) step();

    for (int r = 0; r < 5; r++) apply_rec(recs[r]);

    // Two loads in one frame: only the second word may ever appear.
    for (int i = 0; i < FRAME && (k % FRAME) != 2; i++) step();
    set_word(16'h1111, 4'b0000, {4{7'h79}});
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    set_word(16'h2222, 4'b0100, {4{7'h24}});
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (2 * FRAME) step();

    // Load landing exactly on the boundary edge takes the bypass path.
    for (int i = 0; i < FRAME && ((k + 1) % FRAME) != 0; i++) step();
    set_word(16'h4321, 4'b0001, {7'h19, 7'h30, 7'h24, 7'h79});
    load = 1'b1;
    step();
    load = 1'b0;
    check("pending_after_bypass", 32'(dut.pend_q), 32'h0);
    repeat (FRAME + 4) step();

    // Reset mid-scan with a pending word: the staged value must be discarded.
    repeat (5) step();
    set_word(16'h5555, 4'b1111, {4{7'h12}});
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (2) step();
    do_reset();
    repeat (2 * FRAME) step();

`ifdef SSEG_DIM_EN
    brightness = 4'd4;
    repeat (2 * FRAME) step();
    brightness = 4'd0;
    repeat (FRAME) step();
    brightness = 4'hF;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
